// File: rtl/grf_scoreboard.sv
// Issue-stage hazard scheduler for the general register file: tracks outstanding
// writes and result-ready countdowns per register, decides stall/forward at D.
module grf_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned TW   = 2,
  parameter int unsigned PW   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rs,
  input  logic [4:0]      iss_rt,
  input  logic [TW-1:0]   iss_tuse_rs,
  input  logic [TW-1:0]   iss_tuse_rt,
  input  logic            iss_we,
  input  logic [4:0]      iss_rd,
  input  logic [TW-1:0]   iss_tnew,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  output logic            stall,
  output logic            iss_fire,
  output logic            fwd_rs,
  output logic            fwd_rt,
  output logic [NREG-1:0] busy_vec,
  output logic            err
);

  localparam int unsigned AW = 5;
  localparam logic [PW-1:0] PMAX = '1;

  logic [PW-1:0] pend [NREG];
  logic [TW-1:0] tnew [NREG];

  logic            rs_busy, rt_busy;
  logic            rs_hit, rt_hit, sat_hit;
  logic [NREG-1:0] inc, dec;
  logic            err_set;

  // Issue decision: purely combinational on current scoreboard state.
  always_comb begin
    rs_busy  = (iss_rs != '0) && (pend[iss_rs] != '0);
    rt_busy  = (iss_rt != '0) && (pend[iss_rt] != '0);
    rs_hit   = iss_valid && rs_busy && (tnew[iss_rs] > iss_tuse_rs);
    rt_hit   = iss_valid && rt_busy && (tnew[iss_rt] > iss_tuse_rt);
    sat_hit  = iss_valid && iss_we && (iss_rd != '0) && (pend[iss_rd] == PMAX);
    stall    = rs_hit || rt_hit || sat_hit;
    iss_fire = iss_valid && !stall;
    fwd_rs   = iss_valid && rs_busy && !stall;
    fwd_rt   = iss_valid && rt_busy && !stall;
  end

  // Per-register issue/retire strobes and the untracked-retire error.
  always_comb begin
    inc      = '0;
    dec      = '0;
    busy_vec = '0;
    err_set  = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      inc[r]      = iss_fire && iss_we && (iss_rd == AW'(r));
      dec[r]      = wb_en && (wb_addr == AW'(r));
      busy_vec[r] = (pend[r] != '0);
      if (dec[r] && !inc[r] && (pend[r] == '0)) err_set = 1'b1;
    end
  end

  // Newest issue owns tnew; an issue and a retire on the same edge cancel in pend.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= '0;
        tnew[r] <= '0;
      end
      err <= 1'b0;
    end else begin
      err <= err | err_set;
      for (int r = 0; r < NREG; r++) begin
        if (inc[r]) tnew[r] <= iss_tnew;
        else if (tnew[r] != '0) tnew[r] <= tnew[r] - TW'(1);
        if (inc[r] && !dec[r]) pend[r] <= pend[r] + PW'(1);
        else if (dec[r] && !inc[r] && (pend[r] != '0)) pend[r] <= pend[r] - PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: load-use, branch, same-edge issue/retire,
// saturation, register zero, sticky error and asynchronous reset.
module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid, iss_we, wb_en;
  logic [4:0]  iss_rs, iss_rt, iss_rd, wb_addr;
  logic [1:0]  iss_tuse_rs, iss_tuse_rt, iss_tnew;
  logic        stall, iss_fire, fwd_rs, fwd_rt, err;
  logic [31:0] busy_vec;

  int passed = 0;
  int total  = 0;

  grf_scoreboard dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_tuse_rs(iss_tuse_rs), .iss_tuse_rt(iss_tuse_rt),
    .iss_we(iss_we), .iss_rd(iss_rd), .iss_tnew(iss_tnew),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .stall(stall), .iss_fire(iss_fire), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .busy_vec(busy_vec), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] urs, input logic [1:0] urt,
                       input logic we, input logic [4:0] rd, input logic [1:0] tn,
                       input logic wbe, input logic [4:0] wba);
    iss_valid = v;  iss_rs = rs; iss_rt = rt; iss_tuse_rs = urs; iss_tuse_rt = urt;
    iss_we = we; iss_rd = rd; iss_tnew = tn; wb_en = wbe; wb_addr = wba;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 5, 6, 0, 0, 1, 5, 2, 0, 0);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else passed++;
    total++; if (iss_fire !== 1'b1) $display("FAIL rst_fire got %b want 1", iss_fire); else passed++;
    total++; if (busy_vec !== 32'h0) $display("FAIL rst_busy got %h want 0", busy_vec); else passed++;
    total++; if ({fwd_rs, fwd_rt, err} !== 3'b000) $display("FAIL rst_fwd_err got %b want 000", {fwd_rs, fwd_rt, err}); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    pulse_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 2, 0, 0);                 // lw $5
    #1;
    total++; if (iss_fire !== 1'b1) $display("FAIL lw_fire got %b want 1", iss_fire); else passed++;
    tick();
    drive(1, 5, 0, 1, 3, 1, 6, 1, 0, 0);                 // add reads $5, tuse=1
    #1;
    total++; if (stall !== 1'b1) $display("FAIL lu_stall got %b want 1", stall); else passed++;
    total++; if (iss_fire !== 1'b0) $display("FAIL lu_fire0 got %b want 0", iss_fire); else passed++;
    total++; if (busy_vec !== 32'h0000_0020) $display("FAIL lu_busy got %h want 00000020", busy_vec); else passed++;
    tick();
    #1;
    total++; if ({stall, iss_fire, fwd_rs} !== 3'b011) $display("FAIL lu_release got %b want 011", {stall, iss_fire, fwd_rs}); else passed++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (busy_vec !== 32'h0000_0060) $display("FAIL lu_busy2 got %h want 00000060", busy_vec); else passed++;
    tick();
  endtask

  task automatic test_branch_store();
    pulse_reset();
    drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);                 // add $3
    tick();
    drive(1, 3, 0, 0, 3, 0, 0, 0, 0, 0);                 // beq reads $3, tuse=0
    #1;
    total++; if (stall !== 1'b1) $display("FAIL beq_stall got %b want 1", stall); else passed++;
    tick();
    #1;
    total++; if ({stall, iss_fire, fwd_rs, fwd_rt} !== 4'b0110) $display("FAIL beq_go got %b want 0110", {stall, iss_fire, fwd_rs, fwd_rt}); else passed++;
    tick();
    pulse_reset();
    drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);                 // add $3
    tick();
    drive(1, 0, 3, 0, 2, 0, 0, 0, 0, 0);                 // sw reads $3 as rt, tuse=2
    #1;
    total++; if ({stall, iss_fire, fwd_rs, fwd_rt} !== 4'b0101) $display("FAIL sw_fwd got %b want 0101", {stall, iss_fire, fwd_rs, fwd_rt}); else passed++;
    tick();
  endtask

  task automatic test_issue_retire_same_edge();
    pulse_reset();
    drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 7, 3, 1, 7);                 // new writer + retire of old one
    #1;
    total++; if (iss_fire !== 1'b1) $display("FAIL same_fire got %b want 1", iss_fire); else passed++;
    tick();
    drive(1, 7, 0, 2, 0, 0, 0, 0, 0, 0);                 // tnew[7]=3 > tuse 2
    #1;
    total++; if (busy_vec !== 32'h0000_0080) $display("FAIL same_busy got %h want 00000080", busy_vec); else passed++;
    total++; if (stall !== 1'b1) $display("FAIL same_tnew got %b want 1", stall); else passed++;
    total++; if (err !== 1'b0) $display("FAIL same_err got %b want 0", err); else passed++;
    tick();
    #1;
    total++; if ({stall, fwd_rs} !== 2'b01) $display("FAIL same_drain got %b want 01", {stall, fwd_rs}); else passed++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);                 // retire the single outstanding write
    tick();
    #1;
    total++; if (busy_vec !== 32'h0) $display("FAIL same_retired got %h want 0", busy_vec); else passed++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
      #1;
      total++; if (iss_fire !== 1'b1) $display("FAIL sat_fill%0d got %b want 1", i, iss_fire); else passed++;
      tick();
    end
    #1;
    total++; if (stall !== 1'b1) $display("FAIL sat_stall got %b want 1", stall); else passed++;
    wb_en = 1'b1; wb_addr = 5'd9;
    #1;
    total++; if (stall !== 1'b1) $display("FAIL sat_wb_cycle got %b want 1", stall); else passed++;
    tick();
    wb_en = 1'b0;
    #1;
    total++; if ({stall, iss_fire} !== 2'b01) $display("FAIL sat_release got %b want 01", {stall, iss_fire}); else passed++;
    tick();
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL sat_refull got %b want 1", stall); else passed++;
    total++; if (err !== 1'b0) $display("FAIL sat_err got %b want 0", err); else passed++;
    tick();
  endtask

  task automatic test_reg_zero_and_err();
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
      #1;
      total++; if ({stall, iss_fire, fwd_rs} !== 3'b010) $display("FAIL r0_issue%0d got %b want 010", i, {stall, iss_fire, fwd_rs}); else passed++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);                 // writeback to $0 ignored
    #1;
    total++; if (busy_vec !== 32'h0) $display("FAIL r0_busy got %h want 0", busy_vec); else passed++;
    tick();
    #1;
    total++; if (err !== 1'b0) $display("FAIL r0_err got %b want 0", err); else passed++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 12);                // retire untracked $12
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (err !== 1'b1) $display("FAIL err_set got %b want 1", err); else passed++;
    tick(); tick(); tick();
    #1;
    total++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else passed++;
  endtask

  task automatic test_async_reset();
    pulse_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 2, 0, 0);
    tick();
    tick();                                              // pend[5]=2, tnew[5]=2
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL ar_pre got %b want 1", stall); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({stall, iss_fire} !== 2'b01) $display("FAIL ar_stall got %b want 01", {stall, iss_fire}); else passed++;
    total++; if (busy_vec !== 32'h0) $display("FAIL ar_busy got %h want 0", busy_vec); else passed++;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    test_reset();
    test_load_use();
    test_branch_store();
    test_issue_retire_same_edge();
    test_saturation();
    test_reg_zero_and_err();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Issue-stage hazard scheduler for the 32x32 general register file in the 5-stage pipeline.
- Tracks in-flight writes per architectural register: an outstanding-write count plus a Tnew countdown.
- Decides combinationally whether the instruction in D may issue, stalls it otherwise, and flags operands that must come from the forwarding network rather than the register file.
- Sits between the D-stage decoder and the D/E pipeline register; retires entries on W-stage writeback.

Parameters:
- NREG, 32, number of tracked registers; register 0 is never tracked.
- TW, 2, width of the Tnew/Tuse fields and per-register countdowns.
- PW, 2, width of the per-register outstanding-write counter; saturates at 2^PW-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- iss_valid  in  1  D-stage instruction present
- iss_rs  in  5  source register A
- iss_rt  in  5  source register B
- iss_tuse_rs  in  TW  cycles until rs is consumed, counted from D
- iss_tuse_rt  in  TW  cycles until rt is consumed, counted from D
- iss_we  in  1  instruction writes a register
- iss_rd  in  5  destination register
- iss_tnew  in  TW  cycles until the result exists, counted from E
- wb_en  in  1  W stage writes the register file this cycle
- wb_addr  in  5  W-stage destination
- stall  out  1  hold D, bubble E
- iss_fire  out  1  iss_valid & ~stall
- fwd_rs  out  1  rs value must be taken from the forwarding network
- fwd_rt  out  1  rt value must be taken from the forwarding network
- busy_vec  out  NREG  bit r = outstanding-write count[r] != 0
- err  out  1  sticky: writeback retired an untracked register

Behaviour:
- State per register r (1..31): pend[r] (PW bits) and tnew[r] (TW bits). Register 0 is hardwired to 0 and is never busy.
- Reset (async, immediate):
  - all pend and tnew cleared; err=0.
  - Outputs during and after reset: stall=0, iss_fire=iss_valid, fwd_*=0, busy_vec=0.
- Hazard test for a source s in {rs, rt} with its Tuse u. Hit when all hold:
  - iss_valid=1
  - s != 0
  - pend[s] != 0
  - tnew[s] > u
- Saturation hit when iss_valid & iss_we & iss_rd != 0 & pend[iss_rd] is at its maximum.
- stall = rs hit | rt hit | saturation hit. Purely combinational; no registered latency.
- fwd_rs = iss_valid & rs != 0 & pend[rs] != 0 & ~stall. Same rule for fwd_rt.
- Every posedge, in priority order per register:
  - If iss_fire & iss_we & r == iss_rd (r != 0): tnew[r] <= iss_tnew. The loaded value is not decremented that edge.
  - Otherwise: tnew[r] <= tnew[r] - 1, saturating at 0.
  - pend[r] is incremented when the issue condition above holds for r.
  - pend[r] is decremented when wb_en & wb_addr == r & r != 0.
  - Both on the same register on the same edge: pend[r] is unchanged; tnew[r] takes the new iss_tnew.
  - A decrement with pend[r] == 0: pend stays 0 and err <= 1 (sticky until reset).
- In-order pipeline: the newest issue to a register owns tnew[r]. Older writes retire via pend only.
- wb_addr == 0 is ignored and does not set err.

Test Plan:
- Reset, then lw $5 (iss_we=1, rd=5, tnew=2) fires; next cycle add reading rs=5 (tuse=1) -> stall=1 for exactly 1 cycle. Next cycle fire=1, fwd_rs=1, busy_vec[5]=1.
- add $3 (tnew=1) then beq reading rs=3 (tuse=0) -> 1-cycle stall. add $3 then sw reading rt=3 (tuse=2) -> no stall, fwd_rt=1.
- Issue to $7 and wb_en with wb_addr=7 on the same edge, starting from pend[7]=1 -> pend[7] stays 1, busy_vec[7]=1, tnew[7]=new value.
- Issue three writes to $9 with no writeback (pend=3) -> fourth writer to $9 stalls. Then wb_addr=9 -> the fourth writer fires on the next cycle.
- Instruction reading $0 (rs=0, tuse=0) while a writer with rd=0 is issued -> never stalls, busy_vec=0. Then wb_en with wb_addr=12 and pend[12]=0 -> err=1 and stays 1.
- Assert reset mid-stream with pend[5]=2 and stall=1 -> stall=0 and busy_vec=0 immediately, without waiting for a clock edge.
